// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch-stage controller: address width, FSM encoding and
// the fixed-priority request decode used by the PC-select mux.
package fetch_ctrl_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_EXC   = 2'd3
    } fetch_state_e;

    typedef enum logic [2:0] {
        REQ_NONE  = 3'd0,
        REQ_STALL = 3'd1,
        REQ_JMP   = 3'd2,
        REQ_BR    = 3'd3,
        REQ_EXC   = 3'd4
    } fetch_req_e;

    // Older pipeline stages win: exception, then EX branch, then ID jump, then stall.
    function automatic fetch_req_e pick_req(input logic exc, input logic br,
                                            input logic jmp, input logic stall);
        if (exc)        return REQ_EXC;
        else if (br)    return REQ_BR;
        else if (jmp)   return REQ_JMP;
        else if (stall) return REQ_STALL;
        else            return REQ_NONE;
    endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter for performance statistics; holds at all-ones instead
// of wrapping so an overflowed count is still recognisable.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: boot hold, redirect/stall arbitration onto the fetch
// unit's PC-select pair, pipeline flushes, stall watchdog and perf counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                    BOOT_CYCLES = 4,
    parameter int                    MAX_STALL   = 64,
    parameter logic [ADDR_WIDTH-1:0] EXC_VEC     = 32'h80,
    parameter int                    CNT_W       = 16
) (
    input  logic                  clk_87,
    input  logic                  rst_n_87,
    input  logic                  stall_87,
    input  logic                  jmp_87,
    input  logic [ADDR_WIDTH-1:0] jmp_tgt_87,
    input  logic                  br_taken_87,
    input  logic [ADDR_WIDTH-1:0] br_tgt_87,
    input  logic                  exc_87,
    input  logic [ADDR_WIDTH-1:0] if_npc_87,
    output logic [ADDR_WIDTH-1:0] pc_87,
    output logic                  sel_87,
    output logic                  fetch_rst_87,
    output logic                  flush_if_87,
    output logic                  flush_id_87,
    output logic                  stall_err_87,
    output logic [CNT_W-1:0]      stall_cnt_87,
    output logic [CNT_W-1:0]      redir_cnt_87,
    output logic [1:0]            state_87
);

    localparam int              RUN_W     = $clog2(MAX_STALL + 1);
    localparam logic [3:0]      BOOT_LAST = 4'(BOOT_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_STALL - 1);

    fetch_state_e     state_q, state_d;
    logic [3:0]       boot_q, boot_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             err_q, err_d;
    fetch_req_e       req;
    logic             stall_win, redir_win;

    always_comb begin
        req          = pick_req(exc_87, br_taken_87, jmp_87, stall_87);
        state_d      = state_q;
        boot_d       = boot_q;
        fetch_rst_87 = 1'b0;
        sel_87       = 1'b0;
        pc_87        = if_npc_87;
        flush_if_87  = 1'b0;
        flush_id_87  = 1'b0;
        stall_win    = 1'b0;
        redir_win    = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                fetch_rst_87 = 1'b1;
                pc_87        = '0;
                flush_if_87  = 1'b1;
                flush_id_87  = 1'b1;
                boot_d       = boot_q + 4'd1;
                if (boot_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                    boot_d  = '0;
                end
            end
            ST_RUN, ST_STALL: begin
                unique case (req)
                    REQ_EXC: begin
                        sel_87      = 1'b1;
                        pc_87       = EXC_VEC;
                        flush_if_87 = 1'b1;
                        flush_id_87 = 1'b1;
                        redir_win   = 1'b1;
                        state_d     = ST_EXC;
                    end
                    REQ_BR: begin
                        sel_87      = 1'b1;
                        pc_87       = br_tgt_87;
                        flush_if_87 = 1'b1;
                        flush_id_87 = 1'b1;
                        redir_win   = 1'b1;
                        state_d     = ST_RUN;
                    end
                    REQ_JMP: begin
                        sel_87      = 1'b1;
                        pc_87       = jmp_tgt_87;
                        flush_if_87 = 1'b1;
                        redir_win   = 1'b1;
                        state_d     = ST_RUN;
                    end
                    // Re-present the address already in flight so the fetch regs hold.
                    REQ_STALL: begin
                        sel_87    = 1'b1;
                        pc_87     = if_npc_87 - ADDR_WIDTH'(4);
                        stall_win = 1'b1;
                        state_d   = ST_STALL;
                    end
                    default: state_d = ST_RUN;
                endcase
            end
            // Fetch proceeds sequentially from the vector; only the stale slot is killed.
            ST_EXC: begin
                flush_if_87 = 1'b1;
                state_d     = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Watchdog on consecutive stall cycles; any other cycle restarts the run.
    always_comb begin
        run_d = '0;
        err_d = err_q;
        if (stall_win) begin
            run_d = (run_q == RUN_LAST) ? run_q : run_q + 1'b1;
            if (run_q == RUN_LAST)
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_87 or negedge rst_n_87) begin
        if (!rst_n_87) begin
            state_q <= ST_BOOT;
            boot_q  <= '0;
            run_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_87),
        .rst_ni  (rst_n_87),
        .inc_i   (stall_win),
        .clear_i (1'b0),
        .cnt_o   (stall_cnt_87)
    );

    sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
        .clk_i   (clk_87),
        .rst_ni  (rst_n_87),
        .inc_i   (redir_win),
        .clear_i (1'b0),
        .cnt_o   (redir_cnt_87)
    );

    assign stall_err_87 = err_q;
    assign state_87     = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: priority-mux vector table plus hand sequences
// for boot, stall runs, exception, watchdog, counter saturation and mid-run reset.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk_87, rst_n_87, stall_87, jmp_87, br_taken_87, exc_87;
    logic [31:0] jmp_tgt_87, br_tgt_87, if_npc_87;

    logic [31:0] pc, pc4;
    logic        sel, frst, fif, fid, err, sel4, frst4, fif4, fid4, err4;
    logic [15:0] scnt, rcnt;
    logic [3:0]  scnt4, rcnt4;
    logic [1:0]  st, st4;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_ctrl dut (
        .clk_87(clk_87), .rst_n_87(rst_n_87), .stall_87(stall_87), .jmp_87(jmp_87),
        .jmp_tgt_87(jmp_tgt_87), .br_taken_87(br_taken_87), .br_tgt_87(br_tgt_87),
        .exc_87(exc_87), .if_npc_87(if_npc_87), .pc_87(pc), .sel_87(sel),
        .fetch_rst_87(frst), .flush_if_87(fif), .flush_id_87(fid), .stall_err_87(err),
        .stall_cnt_87(scnt), .redir_cnt_87(rcnt), .state_87(st)
    );

    fetch_ctrl #(.CNT_W(4)) dut4 (
        .clk_87(clk_87), .rst_n_87(rst_n_87), .stall_87(stall_87), .jmp_87(jmp_87),
        .jmp_tgt_87(jmp_tgt_87), .br_taken_87(br_taken_87), .br_tgt_87(br_tgt_87),
        .exc_87(exc_87), .if_npc_87(if_npc_87), .pc_87(pc4), .sel_87(sel4),
        .fetch_rst_87(frst4), .flush_if_87(fif4), .flush_id_87(fid4), .stall_err_87(err4),
        .stall_cnt_87(scnt4), .redir_cnt_87(rcnt4), .state_87(st4)
    );

    initial clk_87 = 1'b0;
    always #5 clk_87 = ~clk_87;

    typedef struct {
        string       name;
        logic [31:0] npc;
        logic        exc;
        logic        br;
        logic [31:0] btgt;
        logic        jmp;
        logic [31:0] jtgt;
        logic        stall;
        logic        sel;
        logic [31:0] pc;
        logic        fif;
        logic        fid;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clr_in();
        stall_87 = 0; jmp_87 = 0; br_taken_87 = 0; exc_87 = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_frst"}, 32'(frst), 32'd1);
        chk({tag, "_sel"},  32'(sel),  32'd0);
        chk({tag, "_pc"},   pc,        32'd0);
        chk({tag, "_fif"},  32'(fif),  32'd1);
        chk({tag, "_fid"},  32'(fid),  32'd1);
        chk({tag, "_st"},   32'(st),   32'd0);
        chk({tag, "_err"},  32'(err),  32'd0);
        chk({tag, "_scnt"}, 32'(scnt), 32'd0);
        chk({tag, "_rcnt"}, 32'(rcnt), 32'd0);
        chk({tag, "_rcnt4"}, 32'(rcnt4), 32'd0);
    endtask

    task automatic boot_len(input string tag);
        int n = 0;
        while (frst === 1'b1 && n < 20) begin
            @(posedge clk_87); #1;
            n++;
        end
        chk({tag, "_boot_cycles"}, 32'(n), 32'd4);
        chk({tag, "_st_run"}, 32'(st), 32'd1);
        chk({tag, "_sel"}, 32'(sel), 32'd0);
    endtask

    initial begin
        //         name         npc           exc br btgt          jmp jtgt          stall sel pc            fif fid
        vecs[0] = '{"none",     32'h100,      0, 0, 32'h0,        0, 32'h0,        0,    0, 32'h100,      0, 0};
        vecs[1] = '{"stall",    32'h10,       0, 0, 32'h0,        0, 32'h0,        1,    1, 32'h0C,       0, 0};
        vecs[2] = '{"stall_0",  32'h0,        0, 0, 32'h0,        0, 32'h0,        1,    1, 32'hFFFFFFFC, 0, 0};
        vecs[3] = '{"jmp_odd",  32'h100,      0, 0, 32'h0,        1, 32'h203,      0,    1, 32'h203,      1, 0};
        vecs[4] = '{"jmp_stl",  32'h100,      0, 0, 32'h0,        1, 32'h300,      1,    1, 32'h300,      1, 0};
        vecs[5] = '{"br_all",   32'h100,      0, 1, 32'h40,       1, 32'h300,      1,    1, 32'h40,       1, 1};
        vecs[6] = '{"exc_br",   32'h100,      1, 1, 32'h44,       0, 32'h0,        0,    1, 32'h80,       1, 1};
        vecs[7] = '{"exc_all",  32'h100,      1, 0, 32'h0,        1, 32'h300,      1,    1, 32'h80,       1, 1};
        vecs[8] = '{"br_ones",  32'h100,      0, 1, 32'hFFFFFFFF, 0, 32'h0,        0,    1, 32'hFFFFFFFF, 1, 1};

        clr_in();
        jmp_tgt_87 = 0; br_tgt_87 = 0; if_npc_87 = 32'h100;
        rst_n_87 = 0;
        #12;
        chk_reset("rst");
        @(negedge clk_87) rst_n_87 = 1;
        boot_len("boot1");

        // Inputs are withdrawn before each posedge, so only the comb mux is exercised.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_87);
            if_npc_87 = vecs[i].npc; exc_87 = vecs[i].exc; br_taken_87 = vecs[i].br;
            br_tgt_87 = vecs[i].btgt; jmp_87 = vecs[i].jmp; jmp_tgt_87 = vecs[i].jtgt;
            stall_87 = vecs[i].stall;
            #1;
            chk({vecs[i].name, "_sel"}, 32'(sel), 32'(vecs[i].sel));
            chk({vecs[i].name, "_pc"},  pc,       vecs[i].pc);
            chk({vecs[i].name, "_fif"}, 32'(fif), 32'(vecs[i].fif));
            chk({vecs[i].name, "_fid"}, 32'(fid), 32'(vecs[i].fid));
            clr_in();
        end
        @(posedge clk_87); #1;
        chk("tbl_st", 32'(st), 32'd1);
        chk("tbl_scnt", 32'(scnt), 32'd0);

        // Three-cycle stall with npc 0x10.
        if_npc_87 = 32'h10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_87) stall_87 = 1;
            #1;
            chk("stall3_sel", 32'(sel), 32'd1);
            chk("stall3_pc", pc, 32'h0C);
        end
        @(posedge clk_87); #1;
        chk("stall3_st", 32'(st), 32'd2);
        chk("stall3_scnt", 32'(scnt), 32'd3);
        @(negedge clk_87) stall_87 = 0;
        @(posedge clk_87); #1;
        chk("stall3_back", 32'(st), 32'd1);

        // Branch + jump + stall together: branch wins.
        @(negedge clk_87);
        br_taken_87 = 1; br_tgt_87 = 32'h40; jmp_87 = 1; jmp_tgt_87 = 32'h300; stall_87 = 1;
        #1;
        chk("brmix_pc", pc, 32'h40);
        chk("brmix_fid", 32'(fid), 32'd1);
        @(posedge clk_87); #1;
        chk("brmix_rcnt", 32'(rcnt), 32'd1);
        chk("brmix_scnt", 32'(scnt), 32'd3);
        chk("brmix_st", 32'(st), 32'd1);
        @(negedge clk_87) clr_in();

        // Exception with branch; exception held through EXC must be ignored there.
        @(negedge clk_87);
        exc_87 = 1; br_taken_87 = 1; br_tgt_87 = 32'h44;
        #1;
        chk("exc_pc", pc, 32'h80);
        chk("exc_fif", 32'(fif), 32'd1);
        @(posedge clk_87); #1;
        chk("exc_st", 32'(st), 32'd3);
        chk("exc_state_sel", 32'(sel), 32'd0);
        chk("exc_state_fif", 32'(fif), 32'd1);
        chk("exc_state_fid", 32'(fid), 32'd0);
        @(posedge clk_87); #1;
        chk("exc_to_run", 32'(st), 32'd1);
        chk("exc_rcnt", 32'(rcnt), 32'd2);
        @(negedge clk_87) clr_in();

        // Watchdog: 40 stalls, a jump breaks the run, then exactly 64 more.
        if_npc_87 = 32'h20;
        @(negedge clk_87) stall_87 = 1;
        repeat (40) @(posedge clk_87);
        @(negedge clk_87);
        jmp_87 = 1; jmp_tgt_87 = 32'h500;
        #1;
        chk("stljmp_pc", pc, 32'h500);
        chk("stljmp_fid", 32'(fid), 32'd0);
        @(negedge clk_87) jmp_87 = 0;
        repeat (63) @(posedge clk_87);
        #1;
        chk("wd63_err", 32'(err), 32'd0);
        chk("wd63_st", 32'(st), 32'd2);
        @(posedge clk_87); #1;
        chk("wd64_err", 32'(err), 32'd1);
        @(negedge clk_87) stall_87 = 0;
        @(posedge clk_87); #1;
        chk("wd_sticky", 32'(err), 32'd1);
        chk("wd_st", 32'(st), 32'd1);
        chk("wd_scnt", 32'(scnt), 32'd107);
        chk("wd_scnt4_sat", 32'(scnt4), 32'hF);
        chk("wd_rcnt", 32'(rcnt), 32'd3);
        chk("wd_rcnt4", 32'(rcnt4), 32'd3);

        // 20 jumps: 4-bit counter pins at 0xF, 16-bit keeps counting.
        @(negedge clk_87) begin jmp_87 = 1; jmp_tgt_87 = 32'h600; end
        repeat (20) @(posedge clk_87);
        @(negedge clk_87) jmp_87 = 0;
        #1;
        chk("jmp20_rcnt4", 32'(rcnt4), 32'hF);
        chk("jmp20_rcnt", 32'(rcnt), 32'd23);

        // Asynchronous reset in the middle of a stall run.
        @(negedge clk_87) stall_87 = 1;
        repeat (3) @(posedge clk_87);
        #2 rst_n_87 = 0;
        #1;
        chk_reset("midrst");
        clr_in();
        @(negedge clk_87) rst_n_87 = 1;
        boot_len("boot2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
